cdf_table_writer: RTL and testbench

CDF_TABLE_WRITER -- requirements
Module: cdf_table_writer

---
 rtl/cdf_table_writer_pkg.sv | 19 +
 rtl/cdf_table_writer_sat_accumulator.sv | 45 ++++
 rtl/cdf_table_writer.sv | 132 +++++++++++++
 tb/tb_cdf_table_writer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cdf_table_writer_pkg.sv
// Shared constants, the saturation limit and FSM state type for the CDF table writer.
package cdf_table_writer_pkg;

  localparam int BIN_COUNT = 256;
  localparam int CDF_W     = 20;
  localparam int ADDR_W    = 16;
  localparam int BUS_W     = 128;
  localparam int BIN_W     = 8;

  localparam logic [CDF_W-1:0] CDF_SAT = 20'hFFFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/cdf_table_writer_sat_accumulator.sv
// Running-sum register with synchronous clear and an adder that clamps at all-ones.
module cdf_sat_accumulator
  import cdf_table_writer_pkg::*;
#(
  parameter int W = CDF_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] sum_o
);

  localparam logic [W-1:0] SAT = {W{1'b1}};

  logic [W:0]   add_s;
  logic [W-1:0] acc_d;
  logic [W-1:0] acc_q;

  // Next accumulator value: a carry out of the top bit means the true sum exceeded the limit.
  always_comb begin
    add_s = {1'b0, acc_q} + {1'b0, data_i};
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = add_s[W] ? SAT : add_s[W-1:0];
    end else begin
      acc_d = acc_q;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign sum_o = acc_q;

endmodule

// File: rtl/cdf_table_writer.sv
// Streams a histogram in, one bin per cycle, and writes its running saturating sum (CDF) back out.
module cdf_table_writer #(
  parameter int BIN_COUNT = cdf_table_writer_pkg::BIN_COUNT,
  parameter int CDF_W     = cdf_table_writer_pkg::CDF_W
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  StartIn,
  input  logic                                  hist_base_offset,
  input  logic                                  output_base_offset,
  output logic [cdf_table_writer_pkg::ADDR_W-1:0] ReadAddress,
  output logic                                  ReadEnable,
  input  logic [cdf_table_writer_pkg::BUS_W-1:0]  ReadBus,
  output logic [cdf_table_writer_pkg::ADDR_W-1:0] WriteAddress,
  output logic [cdf_table_writer_pkg::BUS_W-1:0]  WriteBus,
  output logic                                  WriteEnable,
  output logic                                  Busy,
  output logic                                  Done
);

  import cdf_table_writer_pkg::*;

  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(BIN_COUNT - 1);

  state_e           state_q, state_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic             drain_q, drain_d;
  logic             hoff_q, hoff_d;
  logic             ooff_q, ooff_d;
  logic             start_clr_s;
  logic             rd_valid_q;
  logic [BIN_W-1:0] rd_bin_q;
  logic             wr_en_q;
  logic [BIN_W-1:0] wr_bin_q;
  logic [CDF_W-1:0] cdf_s;
  logic             unused_s;

  // Next-state logic; StartIn only matters in IDLE, and the bin counter holds at the last bin.
  always_comb begin
    state_d     = state_q;
    bin_d       = bin_q;
    drain_d     = drain_q;
    hoff_d      = hoff_q;
    ooff_d      = ooff_q;
    start_clr_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (StartIn) begin
          hoff_d      = hist_base_offset;
          ooff_d      = output_base_offset;
          bin_d       = '0;
          drain_d     = 1'b0;
          start_clr_s = 1'b1;
          state_d     = READ;
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        if (bin_q == LAST_BIN) begin
          drain_d = 1'b0;
          state_d = DRAIN;
        end else begin
          bin_d = bin_q + 8'd1;
        end
      end
      DRAIN: begin
        if (drain_q) begin
          state_d = DONE;
        end else begin
          drain_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state, bin counter and latched region selects.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      bin_q   <= '0;
      drain_q <= 1'b0;
      hoff_q  <= 1'b0;
      ooff_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      drain_q <= drain_d;
      hoff_q  <= hoff_d;
      ooff_q  <= ooff_d;
    end
  end

  // Two-stage pipeline: read data lands one cycle after the strobe, the sum one cycle after that.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      rd_bin_q   <= '0;
      wr_en_q    <= 1'b0;
      wr_bin_q   <= '0;
    end else begin
      rd_valid_q <= (state_q == READ);
      rd_bin_q   <= bin_q;
      wr_en_q    <= rd_valid_q;
      wr_bin_q   <= rd_bin_q;
    end
  end

  cdf_sat_accumulator #(
    .W (CDF_W)
  ) u_acc (
    .clk_i  (clock),
    .rst_i  (reset),
    .clr_i  (start_clr_s),
    .en_i   (rd_valid_q),
    .data_i (ReadBus[CDF_W-1:0]),
    .sum_o  (cdf_s)
  );

  assign unused_s = ^ReadBus[BUS_W-1:CDF_W];

  assign ReadEnable   = (state_q == READ);
  assign ReadAddress  = ReadEnable ? {hoff_q, 7'b0, bin_q} : 16'h0000;
  assign WriteEnable  = wr_en_q;
  assign WriteAddress = wr_en_q ? {ooff_q, 7'b0, wr_bin_q} : 16'h0000;
  assign WriteBus     = wr_en_q ? {{(BUS_W-CDF_W){1'b0}}, cdf_s} : {BUS_W{1'b0}};
  assign Busy         = (state_q != IDLE);
  assign Done         = (state_q == DONE);

endmodule

// File: tb/tb_cdf_table_writer.sv
// Directed bench: histogram memory model, per-write monitor, vector table and abort/re-start sequences.
module tb_cdf_table_writer;

  logic         clock = 1'b0;
  logic         reset;
  logic         StartIn;
  logic         hist_base_offset;
  logic         output_base_offset;
  logic [15:0]  ReadAddress;
  logic         ReadEnable;
  logic [127:0] ReadBus;
  logic [15:0]  WriteAddress;
  logic [127:0] WriteBus;
  logic         WriteEnable;
  logic         Busy;
  logic         Done;

  always #5 clock = ~clock;

  cdf_table_writer dut (
    .clock              (clock),
    .reset              (reset),
    .StartIn            (StartIn),
    .hist_base_offset   (hist_base_offset),
    .output_base_offset (output_base_offset),
    .ReadAddress        (ReadAddress),
    .ReadEnable         (ReadEnable),
    .ReadBus            (ReadBus),
    .WriteAddress       (WriteAddress),
    .WriteBus           (WriteBus),
    .WriteEnable        (WriteEnable),
    .Busy               (Busy),
    .Done               (Done)
  );

  typedef struct {
    int          pat;
    bit          hoff;
    bit          ooff;
    logic [19:0] e0;
    logic [19:0] e14;
    logic [19:0] e15;
    logic [19:0] e255;
  } vec_t;

  vec_t vecs[5];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int t0 = 0;
  int rd_n = 0;
  int wr_n = 0;
  int done_n = 0;
  int busy_falls = 0;
  bit busy_prev = 1'b0;
  bit mon_on = 1'b0;
  bit exp_hoff = 1'b0;
  bit exp_ooff = 1'b0;
  logic        prev_re = 1'b0;
  logic [15:0] prev_addr = 16'h0;
  logic [19:0] hist[256];
  logic [19:0] exp_cdf[256];
  logic [19:0] cap[256];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic void load(input int pat);
    longint s = 0;
    for (int k = 0; k < 256; k++) begin
      case (pat)
        0:       hist[k] = 20'd4;
        1:       hist[k] = (k == 255) ? 20'd1000 : 20'd0;
        2:       hist[k] = 20'h10000;
        3:       hist[k] = 20'(k);
        4:       hist[k] = 20'hFFFFF;
        default: hist[k] = 20'd0;
      endcase
      s = s + longint'(hist[k]);
      if (s > 64'hFFFFF) s = 64'hFFFFF;
      exp_cdf[k] = 20'(s);
      cap[k] = 20'h0;
    end
  endfunction

  always @(posedge clock) cyc++;

  // Memory model: data for a strobed address appears during the following cycle; junk otherwise.
  always @(negedge clock) begin
    ReadBus = prev_re ? {{27{4'hA}}, hist[prev_addr[7:0]]} : {32{4'h5}};
    prev_re = ReadEnable;
    prev_addr = ReadAddress;
  end

  // Monitor: every read, write and Done is checked for address, data and cycle.
  always @(negedge clock) begin
    if (mon_on) begin
      if (ReadEnable) begin
        chk("rd_addr", ReadAddress, {exp_hoff, 7'b0, 8'(rd_n)});
        chk("rd_cycle", cyc, t0 + rd_n);
        rd_n++;
      end else begin
        chk("rd_addr_idle", ReadAddress, 16'h0);
      end
      if (WriteEnable) begin
        chk("wr_addr", WriteAddress, {exp_ooff, 7'b0, 8'(wr_n)});
        chk("wr_data", WriteBus, {108'h0, exp_cdf[wr_n % 256]});
        chk("wr_cycle", cyc, t0 + wr_n + 2);
        cap[wr_n % 256] = WriteBus[19:0];
        wr_n++;
      end else begin
        chk("wr_addr_idle", WriteAddress, 16'h0);
        chk("wr_bus_idle", WriteBus, 128'h0);
      end
      if (Done) begin
        chk("done_cycle", cyc, t0 + 258);
        done_n++;
      end
      if (busy_prev && !Busy) busy_falls++;
      busy_prev = Busy;
    end
  end

  task automatic start_build(input bit h, input bit o);
    @(negedge clock);
    hist_base_offset = h;
    output_base_offset = o;
    exp_hoff = h;
    exp_ooff = o;
    rd_n = 0;
    wr_n = 0;
    done_n = 0;
    busy_falls = 0;
    t0 = cyc + 1;
    StartIn = 1'b1;
    @(negedge clock);
    StartIn = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 400 && !Done; i++) @(negedge clock);
    chk("done_seen", Done, 1'b1);
  endtask

  task automatic check_counts(input string tag, input int rd, input int wr, input int dn, input int bf);
    chk({tag, "_reads"}, rd_n, rd);
    chk({tag, "_writes"}, wr_n, wr);
    chk({tag, "_dones"}, done_n, dn);
    chk({tag, "_busy_falls"}, busy_falls, bf);
  endtask

  initial begin
    vecs[0] = '{0, 1'b0, 1'b1, 20'd4, 20'd60, 20'd64, 20'd1024};
    vecs[1] = '{1, 1'b0, 1'b1, 20'd0, 20'd0, 20'd0, 20'd1000};
    vecs[2] = '{2, 1'b1, 1'b0, 20'h10000, 20'hF0000, 20'hFFFFF, 20'hFFFFF};
    vecs[3] = '{3, 1'b1, 1'b1, 20'd0, 20'd105, 20'd120, 20'd32640};
    vecs[4] = '{4, 1'b0, 1'b0, 20'hFFFFF, 20'hFFFFF, 20'hFFFFF, 20'hFFFFF};

    reset = 1'b1;
    StartIn = 1'b0;
    hist_base_offset = 1'b0;
    output_base_offset = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_re", ReadEnable, 1'b0);
    chk("rst_we", WriteEnable, 1'b0);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_done", Done, 1'b0);
    chk("rst_raddr", ReadAddress, 16'h0);
    chk("rst_waddr", WriteAddress, 16'h0);
    chk("rst_wbus", WriteBus, 128'h0);
    // Reset must win over a simultaneous start request.
    StartIn = 1'b1;
    @(negedge clock);
    chk("rst_prio_busy", Busy, 1'b0);
    StartIn = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    chk("idle_busy", Busy, 1'b0);
    mon_on = 1'b1;

    for (int i = 0; i < 5; i++) begin
      load(vecs[i].pat);
      start_build(vecs[i].hoff, vecs[i].ooff);
      wait_done();
      repeat (4) @(negedge clock);
      check_counts("vec", 256, 256, 1, 1);
      chk("cdf0", cap[0], vecs[i].e0);
      chk("cdf14", cap[14], vecs[i].e14);
      chk("cdf15", cap[15], vecs[i].e15);
      chk("cdf255", cap[255], vecs[i].e255);
    end

    // Start re-pulsed mid-build (with offsets flipped) and again in the DONE cycle.
    load(0);
    start_build(1'b0, 1'b1);
    while (cyc < t0 + 50) @(negedge clock);
    StartIn = 1'b1;
    hist_base_offset = 1'b1;
    output_base_offset = 1'b0;
    @(negedge clock);
    StartIn = 1'b0;
    wait_done();
    StartIn = 1'b1;
    @(negedge clock);
    StartIn = 1'b0;
    repeat (300) @(negedge clock);
    check_counts("restart", 256, 256, 1, 1);
    chk("restart_cdf255", cap[255], 20'd1024);
    hist_base_offset = 1'b0;
    output_base_offset = 1'b0;

    // Reset at bin 100 aborts the build; a fresh start then produces a full table.
    load(3);
    start_build(1'b1, 1'b0);
    while (cyc < t0 + 100) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("abort_we", WriteEnable, 1'b0);
    chk("abort_busy", Busy, 1'b0);
    chk("abort_re", ReadEnable, 1'b0);
    reset = 1'b0;
    repeat (20) @(negedge clock);
    check_counts("abort", 101, 99, 0, 1);

    load(0);
    start_build(1'b0, 1'b1);
    wait_done();
    repeat (4) @(negedge clock);
    check_counts("rebuild", 256, 256, 1, 1);
    chk("rebuild_cdf0", cap[0], 20'd4);
    chk("rebuild_cdf255", cap[255], 20'd1024);

    mon_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
